mem_stage_pipe: RTL and testbench

Parametrised pipeline memory stage with an internal word-addressed data RAM. Stores support per-byte write enables. Loads take a configurable multi-cycle read latency, during which the stage back-pressures the execute stage through a valid/ready handshake. Out-of-range accesses raise a fault instead of touching memory. The stage sits between execute and writeback and registers the writeback bundle: write-enable, data and destination register.

---
 rtl/mem_stage_pipe.sv | 168 ++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// rtl/mem_stage_pipe.sv - pipeline memory stage with byte-lane stores and multi-cycle loads
module mem_stage_pipe #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8,
  parameter int REG_W  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mem_we,
  input  logic                mem_re,
  input  logic                reg_we,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   result,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [REG_W-1:0]    reg_to_write,
  output logic                out_valid,
  output logic                reg_we_out,
  output logic [DATA_W-1:0]   data_to_write_out,
  output logic [REG_W-1:0]    reg_to_write_out,
  output logic                fault_out
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  // Two bits cover the largest countdown (RD_LAT-1 = 3).
  localparam int CNT_W = 2;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ld_reg_we_q, ld_reg_we_d;
  logic [REG_W-1:0]    ld_reg_q, ld_reg_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic                out_valid_q, out_valid_d;
  logic                reg_we_out_q, reg_we_out_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [REG_W-1:0]    reg_out_q, reg_out_d;
  logic                fault_q, fault_d;

  logic [DATA_W-1:0]   ram_q [0:DEPTH-1];

  logic [ADDR_W-1:0]   addr;
  logic                accept;
  logic                is_store;
  logic                is_load;
  logic                out_of_range;
  logic                ram_wr;

  // Decode the presented instruction; a store wins when both mem_we and mem_re are set.
  always_comb begin
    addr         = result[ADDR_W-1:0];
    accept       = in_valid && (state_q == IDLE);
    is_store     = mem_we;
    is_load      = mem_re && !mem_we;
    out_of_range = (mem_we || mem_re) && ((result >> ADDR_W) != '0);
    ram_wr       = accept && is_store && !out_of_range;
  end

  // Next-state and writeback bundle; outputs other than out_valid hold when nothing completes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ld_reg_we_d  = ld_reg_we_q;
    ld_reg_d     = ld_reg_q;
    rd_data_d    = rd_data_q;
    out_valid_d  = 1'b0;
    reg_we_out_d = reg_we_out_q;
    data_out_d   = data_out_q;
    reg_out_d    = reg_out_q;
    fault_d      = fault_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (out_of_range) begin
            out_valid_d  = 1'b1;
            fault_d      = 1'b1;
            reg_we_out_d = 1'b0;
            data_out_d   = '0;
            reg_out_d    = reg_to_write;
          end else if (is_load) begin
            // The word is captured at issue; no store can land while we wait.
            state_d     = LOAD_WAIT;
            cnt_d       = CNT_W'(RD_LAT - 1);
            ld_reg_we_d = reg_we;
            ld_reg_d    = reg_to_write;
            rd_data_d   = ram_q[addr];
          end else begin
            out_valid_d  = 1'b1;
            fault_d      = 1'b0;
            reg_we_out_d = reg_we;
            data_out_d   = result;
            reg_out_d    = reg_to_write;
          end
        end
      end
      LOAD_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d      = IDLE;
          out_valid_d  = 1'b1;
          fault_d      = 1'b0;
          reg_we_out_d = ld_reg_we_q;
          data_out_d   = rd_data_q;
          reg_out_d    = ld_reg_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, load context and output registers; reset drops any pending load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ld_reg_we_q  <= 1'b0;
      ld_reg_q     <= '0;
      rd_data_q    <= '0;
      out_valid_q  <= 1'b0;
      reg_we_out_q <= 1'b0;
      data_out_q   <= '0;
      reg_out_q    <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ld_reg_we_q  <= ld_reg_we_d;
      ld_reg_q     <= ld_reg_d;
      rd_data_q    <= rd_data_d;
      out_valid_q  <= out_valid_d;
      reg_we_out_q <= reg_we_out_d;
      data_out_q   <= data_out_d;
      reg_out_q    <= reg_out_d;
      fault_q      <= fault_d;
    end
  end

  // Data RAM with per-lane write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && ram_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_en[i]) begin
          ram_q[addr][8*i +: 8] <= store_data[8*i +: 8];
        end
      end
    end
  end

  assign in_ready          = (state_q == IDLE);
  assign out_valid         = out_valid_q;
  assign reg_we_out        = reg_we_out_q;
  assign data_to_write_out = data_out_q;
  assign reg_to_write_out  = reg_out_q;
  assign fault_out         = fault_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb/tb_mem_stage_pipe.sv - directed self-checking bench for mem_stage_pipe
module tb_mem_stage_pipe;

  logic        clk;
  logic        reset_a, reset_b;
  logic        in_valid_a, in_valid_b;
  logic        mem_we, mem_re, reg_we;
  logic [2:0]  byte_en;
  logic [23:0] result, store_data;
  logic [3:0]  reg_to_write;

  logic        in_ready_a, out_valid_a, reg_we_out_a, fault_a;
  logic [23:0] data_a;
  logic [3:0]  reg_a;
  logic        in_ready_b, out_valid_b, reg_we_out_b, fault_b;
  logic [23:0] data_b;
  logic [3:0]  reg_b;

  int checks = 0;
  int failures = 0;

  mem_stage_pipe #(.DATA_W(24), .ADDR_W(8), .REG_W(4), .RD_LAT(2)) dut_a (
    .clk(clk), .reset(reset_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .mem_we(mem_we), .mem_re(mem_re), .reg_we(reg_we), .byte_en(byte_en),
    .result(result), .store_data(store_data), .reg_to_write(reg_to_write),
    .out_valid(out_valid_a), .reg_we_out(reg_we_out_a), .data_to_write_out(data_a),
    .reg_to_write_out(reg_a), .fault_out(fault_a)
  );

  mem_stage_pipe #(.DATA_W(24), .ADDR_W(8), .REG_W(4), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .mem_we(mem_we), .mem_re(mem_re), .reg_we(reg_we), .byte_en(byte_en),
    .result(result), .store_data(store_data), .reg_to_write(reg_to_write),
    .out_valid(out_valid_b), .reg_we_out(reg_we_out_b), .data_to_write_out(data_b),
    .reg_to_write_out(reg_b), .fault_out(fault_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic re, input logic rwe,
                       input logic [2:0] be, input logic [23:0] res,
                       input logic [23:0] sd, input logic [3:0] rd);
    in_valid_a   = v;
    mem_we       = we;
    mem_re       = re;
    reg_we       = rwe;
    byte_en      = be;
    result       = res;
    store_data   = sd;
    reg_to_write = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    in_valid_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h0, 24'h0, 4'h0);
    step();
    step();
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_reg_we", 32'(reg_we_out_a), 32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_reg", 32'(reg_a), 32'd0);
    check("rst_fault", 32'(fault_a), 32'd0);
    check("rst_in_ready", 32'(in_ready_a), 32'd1);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // ALU op
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 24'h00ABCD, 24'h0, 4'h5);
    step();
    check("alu_valid", 32'(out_valid_a), 32'd1);
    check("alu_data", 32'(data_a), 32'h00ABCD);
    check("alu_reg", 32'(reg_a), 32'd5);
    check("alu_fault", 32'(fault_a), 32'd0);
    check("alu_reg_we", 32'(reg_we_out_a), 32'd1);

    // Full-word store, then load of the same address on the next edge
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 24'h000010, 24'h123456, 4'h0);
    step();
    check("st_valid", 32'(out_valid_a), 32'd1);
    check("st_data", 32'(data_a), 32'h000010);
    check("st_reg_we", 32'(reg_we_out_a), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 24'h000010, 24'h0, 4'h3);
    step();
    check("ld_stall1_ready", 32'(in_ready_a), 32'd0);
    check("ld_stall1_valid", 32'(out_valid_a), 32'd0);
    // Junk while stalled must be ignored
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b111, 24'h000010, 24'hDEAD00, 4'hF);
    step();
    check("ld_stall2_ready", 32'(in_ready_a), 32'd0);
    check("ld_stall2_valid", 32'(out_valid_a), 32'd0);
    step();
    check("ld_ready_back", 32'(in_ready_a), 32'd1);
    check("ld_valid", 32'(out_valid_a), 32'd1);
    check("ld_data", 32'(data_a), 32'h123456);
    check("ld_reg_we", 32'(reg_we_out_a), 32'd1);
    check("ld_reg", 32'(reg_a), 32'd3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h0, 24'h0, 4'h0);
    step();
    check("idle_valid", 32'(out_valid_a), 32'd0);
    check("idle_hold_data", 32'(data_a), 32'h123456);

    // Partial-lane store over 123456
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 24'h000010, 24'hAABBCC, 4'h0);
    step();
    check("bst_valid", 32'(out_valid_a), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 24'h000010, 24'h0, 4'h7);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h0, 24'h0, 4'h0);
    step();
    step();
    check("bld_valid", 32'(out_valid_a), 32'd1);
    check("bld_data", 32'(data_a), 32'h12BB56);
    check("bld_reg", 32'(reg_a), 32'd7);

    // Seed address 0, then out-of-range load and store
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 24'h000000, 24'h5A5A5A, 4'h0);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 24'h000100, 24'h0, 4'h2);
    step();
    check("oor_ld_ready", 32'(in_ready_a), 32'd1);
    check("oor_ld_valid", 32'(out_valid_a), 32'd1);
    check("oor_ld_fault", 32'(fault_a), 32'd1);
    check("oor_ld_reg_we", 32'(reg_we_out_a), 32'd0);
    check("oor_ld_data", 32'(data_a), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b111, 24'h000100, 24'hFFFFFF, 4'h2);
    step();
    check("oor_st_fault", 32'(fault_a), 32'd1);
    check("oor_st_data", 32'(data_a), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 24'h000000, 24'h0, 4'h9);
    step();
    check("ld0_fault_cleared_later_ready", 32'(in_ready_a), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h0, 24'h0, 4'h0);
    step();
    step();
    check("ld0_valid", 32'(out_valid_a), 32'd1);
    check("ld0_data", 32'(data_a), 32'h5A5A5A);
    check("ld0_fault", 32'(fault_a), 32'd0);

    // Back-to-back ALU ops
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 24'(i * 24'h111111), 24'h0, 4'(i));
      step();
      check("b2b_valid", 32'(out_valid_a), 32'd1);
      check("b2b_data", 32'(data_a), 32'(i * 24'h111111));
      check("b2b_reg", 32'(reg_a), 32'(i));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h0, 24'h0, 4'h0);
    step();
    check("b2b_end_valid", 32'(out_valid_a), 32'd0);

    // Reset during LOAD_WAIT on the RD_LAT=3 instance
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 24'h000010, 24'h0, 4'h6);
    in_valid_b = 1'b1;
    step();
    check("rwl_ready_low", 32'(in_ready_b), 32'd0);
    in_valid_b = 1'b0;
    reset_b = 1'b1;
    step();
    check("rwl_ready_after_rst", 32'(in_ready_b), 32'd1);
    check("rwl_valid_after_rst", 32'(out_valid_b), 32'd0);
    reset_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rwl_no_valid", 32'(out_valid_b), 32'd0);
      check("rwl_ready", 32'(in_ready_b), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
